// File: rtl/dense_forward_if.sv
// Operand/result handshake bundle for dense_forward.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid and ready are both high.
interface dense_forward_if #(
    parameter int size      = 3,
    parameter int data_size = 16
);
    logic                             in_valid;
    logic                             in_ready;
    logic [size*data_size-1:0]        x;
    logic [size*size*data_size-1:0]   weight;
    logic [size*data_size-1:0]        bias;
    logic                             out_valid;
    logic                             out_ready;
    logic [size*data_size-1:0]        z;
    logic                             busy;

    modport master (
        output in_valid, x, weight, bias, out_ready,
        input  in_ready, out_valid, z, busy
    );

    modport slave (
        input  in_valid, x, weight, bias, out_ready,
        output in_ready, out_valid, z, busy
    );
endinterface

// File: rtl/dense_forward.sv
// Dense-layer pre-activation z = bias + W*x with one shared signed multiplier, one product per clock.
// Optional macro DENSE_FORWARD_RELU_EN clamps each saturated z element at zero.
module dense_forward #(
    parameter int size      = 3,
    parameter int data_size = 16,
    parameter int frac_bits = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    dense_forward_if.slave     bus,
    output logic [1:0]         state_dbg
);
    localparam int IW    = (size > 1) ? $clog2(size) : 1;
    localparam int KW    = (size > 1) ? $clog2(size*size) : 1;
    localparam int ACC_W = 2*data_size + $clog2(size) + 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-data_size+1){1'b0}}, {(data_size-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-data_size+1){1'b1}}, {(data_size-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic signed [data_size-1:0] x_r [size];
    logic signed [data_size-1:0] w_r [size*size];
    logic signed [data_size-1:0] b_r [size];
    logic signed [data_size-1:0] z_r [size];

    logic [IW-1:0]              i_idx, j_idx;
    logic [KW-1:0]              k_idx;
    logic signed [ACC_W-1:0]    acc, acc_nxt, shifted, bias_nxt;
    logic signed [2*data_size-1:0] prod;
    logic signed [data_size-1:0] z_new;
    logic                       last_i, last_j, accept;

    function automatic logic signed [ACC_W-1:0] bias_acc(input logic signed [data_size-1:0] b);
        return ACC_W'(b) <<< frac_bits;
    endfunction

    assign accept    = bus.in_valid & bus.in_ready;
    assign last_i    = (i_idx == IW'(size-1));
    assign last_j    = (j_idx == IW'(size-1));
    assign state_dbg = state;

    // Single MAC datapath; >>> floors, then clamp to the element range.
    always_comb begin
        prod    = x_r[i_idx] * w_r[k_idx];
        acc_nxt = acc + ACC_W'(prod);
        shifted = acc_nxt >>> frac_bits;
        if (shifted > SAT_MAX)
            z_new = SAT_MAX[data_size-1:0];
        else if (shifted < SAT_MIN)
            z_new = SAT_MIN[data_size-1:0];
        else
            z_new = shifted[data_size-1:0];
`ifdef DENSE_FORWARD_RELU_EN
        if (z_new[data_size-1])
            z_new = '0;
`else
`endif
        bias_nxt = '0;
        if (!last_j)
            bias_nxt = bias_acc(b_r[j_idx + IW'(1)]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept)            state_nxt = S_MAC;
            S_MAC:  if (last_i && last_j)  state_nxt = S_DONE;
            S_DONE: if (bus.out_ready)     state_nxt = S_IDLE;
            default:                       state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == S_IDLE);
        bus.busy      = (state == S_MAC);
        bus.out_valid = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_idx <= '0;
            j_idx <= '0;
            k_idx <= '0;
            acc   <= '0;
            for (int n = 0; n < size; n++) begin
                x_r[n] <= '0;
                b_r[n] <= '0;
                z_r[n] <= '0;
            end
            for (int n = 0; n < size*size; n++)
                w_r[n] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        for (int n = 0; n < size; n++) begin
                            x_r[n] <= bus.x[n*data_size +: data_size];
                            b_r[n] <= bus.bias[n*data_size +: data_size];
                        end
                        for (int n = 0; n < size*size; n++)
                            w_r[n] <= bus.weight[n*data_size +: data_size];
                        i_idx <= '0;
                        j_idx <= '0;
                        k_idx <= '0;
                        acc   <= bias_acc(bus.bias[data_size-1:0]);
                    end
                end
                S_MAC: begin
                    k_idx <= (last_i && last_j) ? '0 : k_idx + KW'(1);
                    if (!last_i) begin
                        i_idx <= i_idx + IW'(1);
                        acc   <= acc_nxt;
                    end else begin
                        z_r[j_idx] <= z_new;
                        i_idx      <= '0;
                        j_idx      <= last_j ? '0 : j_idx + IW'(1);
                        acc        <= bias_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < size; g++) begin : g_zpack
        assign bus.z[g*data_size +: data_size] = z_r[g];
    end
endmodule
